// File: rtl/cache_bus_pkg.sv
// Shared types and line geometry for the cache-to-memory burst adapter.
package cache_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WDATA,
        S_WRESP,
        S_RDATA,
        S_DONE
    } state_e;

    function automatic int line_words(input int off_len);
        return 1 << off_len;
    endfunction

    function automatic int line_width(input int data_w, input int off_len);
        return data_w * line_words(off_len);
    endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line register with beat counter: serialises writebacks, assembles fills.
module line_beat_buffer
    import cache_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          i_load,
    input  logic                                          i_clr,
    input  logic                                          i_adv,
    input  logic                                          i_wr,
    input  logic                                          i_commit,
    input  logic [line_width(DATA_WIDTH, OFFSET_LENGTH)-1:0] i_wline,
    input  logic [DATA_WIDTH-1:0]                         i_wdata,
    output logic [DATA_WIDTH-1:0]                         o_word,
    output logic                                          o_last,
    output logic [line_width(DATA_WIDTH, OFFSET_LENGTH)-1:0] o_rline
);

    localparam int LINE_WORDS = line_words(OFFSET_LENGTH);

    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] r_line;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] r_rline;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] w_line;
    logic [OFFSET_LENGTH-1:0]              r_cnt;

    always_comb begin
        w_line = r_line;
        if (i_wr) begin
            w_line[r_cnt] = i_wdata;
        end
    end

    // The visible fill line only moves when a full burst has landed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line  <= '0;
            r_rline <= '0;
            r_cnt   <= '0;
        end else begin
            if (i_load) begin
                r_line <= i_wline;
            end else begin
                r_line <= w_line;
            end
            if (i_commit) begin
                r_rline <= w_line;
            end
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_adv) begin
                r_cnt <= r_cnt + OFFSET_LENGTH'(1);
            end
        end
    end

    assign o_word  = r_line[r_cnt];
    assign o_last  = &r_cnt;
    assign o_rline = r_rline;

endmodule

// File: rtl/cache_bus_adapter.sv
// Converts cache line fill/writeback commands into memory bursts.
module cache_bus_adapter
    import cache_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int OFFSET_LENGTH = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          cmd_valid,
    input  logic                                          cmd_store,
    input  logic                                          cmd_rready,
    input  logic [ADDR_WIDTH-1:0]                         cmd_addr,
    input  logic [line_width(DATA_WIDTH, OFFSET_LENGTH)-1:0] cmd_wline,
    output logic [line_width(DATA_WIDTH, OFFSET_LENGTH)-1:0] rline,
    output logic                                          line_valid,
    output logic                                          line_ready,
    output logic                                          mem_req_valid,
    input  logic                                          mem_req_ready,
    output logic                                          mem_req_write,
    output logic [ADDR_WIDTH-1:0]                         mem_req_addr,
    output logic [OFFSET_LENGTH-1:0]                      mem_req_len,
    output logic [DATA_WIDTH-1:0]                         mem_wdata,
    output logic                                          mem_wvalid,
    input  logic                                          mem_wready,
    output logic                                          mem_wlast,
    input  logic [DATA_WIDTH-1:0]                         mem_rdata,
    input  logic                                          mem_rvalid,
    input  logic                                          mem_rlast,
    input  logic                                          mem_bvalid,
    output logic                                          protocol_err
);

    localparam int LINE_WORDS = line_words(OFFSET_LENGTH);

    state_e                  r_state;
    state_e                  w_state_n;
    logic                    r_store;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_adv;
    logic                    w_wr;
    logic                    w_commit;
    logic                    w_last;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_unused;

    assign w_unused = ^{cmd_rready, cmd_addr[OFFSET_LENGTH-1:0]};

    line_beat_buffer #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OFFSET_LENGTH (OFFSET_LENGTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_accept && cmd_store),
        .i_clr    (w_accept),
        .i_adv    (w_adv),
        .i_wr     (w_wr),
        .i_commit (w_commit),
        .i_wline  (cmd_wline),
        .i_wdata  (mem_rdata),
        .o_word   (w_word),
        .o_last   (w_last),
        .o_rline  (rline)
    );

    always_comb begin
        w_state_n     = r_state;
        w_accept      = 1'b0;
        w_adv         = 1'b0;
        w_wr          = 1'b0;
        w_commit      = 1'b0;
        mem_req_valid = 1'b0;
        mem_wvalid    = 1'b0;
        mem_wlast     = 1'b0;
        line_valid    = 1'b0;
        line_ready    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept  = 1'b1;
                    w_state_n = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_n = r_store ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                mem_wvalid = 1'b1;
                mem_wlast  = w_last;
                if (mem_wready) begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_state_n = S_WRESP;
                    end
                end
            end
            S_WRESP: begin
                if (mem_bvalid) begin
                    w_state_n = S_DONE;
                end
            end
            S_RDATA: begin
                if (mem_rvalid) begin
                    w_wr  = 1'b1;
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_commit  = 1'b1;
                        w_state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A withdrawn command still finishes its burst, silently.
                line_valid = cmd_valid && !r_store;
                line_ready = cmd_valid && r_store;
                w_state_n  = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_store <= 1'b0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                r_store <= cmd_store;
                r_addr  <= {cmd_addr[ADDR_WIDTH-1:OFFSET_LENGTH],
                            OFFSET_LENGTH'(0)};
            end
            if (w_wr && (mem_rlast != w_last)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req_write = r_store;
    assign mem_req_addr  = r_addr;
    assign mem_req_len   = OFFSET_LENGTH'(LINE_WORDS - 1);
    assign mem_wdata     = w_word;
    assign protocol_err  = r_err;

endmodule

// File: tb/tb_cache_bus_adapter.sv
// Directed bench: fills, writebacks, rlast errors, dropped command, reset.
module tb_cache_bus_adapter;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_store, cmd_rready;
    logic [63:0]   cmd_addr;
    logic [1023:0] cmd_wline;
    logic [1023:0] rline;
    logic          line_valid, line_ready;
    logic          mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0]   mem_req_addr;
    logic [3:0]    mem_req_len;
    logic [63:0]   mem_wdata;
    logic          mem_wvalid, mem_wready, mem_wlast;
    logic [63:0]   mem_rdata;
    logic          mem_rvalid, mem_rlast, mem_bvalid;
    logic          protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    int          req_cnt = 0;
    int          lv_cnt  = 0;
    int          lr_cnt  = 0;
    int          wbeats  = 0;
    logic        req_w;
    logic [63:0] req_a;
    logic [3:0]  req_l;
    logic [63:0] wdat_log [64];
    logic        wlast_log [64];

    cache_bus_adapter dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_store     (cmd_store),
        .cmd_rready    (cmd_rready),
        .cmd_addr      (cmd_addr),
        .cmd_wline     (cmd_wline),
        .rline         (rline),
        .line_valid    (line_valid),
        .line_ready    (line_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_len   (mem_req_len),
        .mem_wdata     (mem_wdata),
        .mem_wvalid    (mem_wvalid),
        .mem_wready    (mem_wready),
        .mem_wlast     (mem_wlast),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .mem_rlast     (mem_rlast),
        .mem_bvalid    (mem_bvalid),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            req_cnt <= req_cnt + 1;
            req_w   <= mem_req_write;
            req_a   <= mem_req_addr;
            req_l   <= mem_req_len;
        end
        if (line_valid) lv_cnt <= lv_cnt + 1;
        if (line_ready) lr_cnt <= lr_cnt + 1;
        if (mem_wvalid && mem_wready) begin
            if (wbeats < 64) begin
                wdat_log[wbeats]  <= mem_wdata;
                wlast_log[wbeats] <= mem_wlast;
            end
            wbeats <= wbeats + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req_valid) break;
        end
        chk("req_wait", {63'd0, mem_req_valid}, 64'd1);
    endtask

    task automatic do_fill(input logic [63:0] addr, input logic [63:0] base,
                           input int rlast_beat, input int drop_beat,
                           input int req_delay);
        cmd_valid = 1'b1;
        cmd_store = 1'b0;
        cmd_addr  = addr;
        wait_req();
        repeat (req_delay) step();
        chk("fill_req_addr", mem_req_addr, addr);
        chk("fill_req_len", {60'd0, mem_req_len}, 64'd15);
        chk("fill_req_write", {63'd0, mem_req_write}, 64'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == drop_beat) cmd_valid = 1'b0;
            mem_rvalid = 1'b1;
            mem_rdata  = base + 64'(k);
            mem_rlast  = (k == rlast_beat);
            step();
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
    endtask

    task automatic check_rline(input logic [63:0] base);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("rline_w%0d", k), rline[k*64 +: 64], base + 64'(k));
        end
    endtask

    task automatic start_store(input logic [63:0] addr,
                               input logic [63:0] base);
        for (int k = 0; k < 16; k++) begin
            cmd_wline[k*64 +: 64] = base + 64'(k);
        end
        cmd_valid = 1'b1;
        cmd_store = 1'b1;
        cmd_addr  = addr;
        wait_req();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
    endtask

    initial begin
        int lv0, lr0, rq0, wb0, g, nlast;
        reset         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_store     = 1'b0;
        cmd_rready    = 1'b1;
        cmd_addr      = '0;
        cmd_wline     = '0;
        mem_req_ready = 1'b0;
        mem_wready    = 1'b0;
        mem_rdata     = '0;
        mem_rvalid    = 1'b0;
        mem_rlast     = 1'b0;
        mem_bvalid    = 1'b0;

        repeat (2) step();
        chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_wvalid", {63'd0, mem_wvalid}, 64'd0);
        chk("rst_wlast", {63'd0, mem_wlast}, 64'd0);
        chk("rst_line_valid", {63'd0, line_valid}, 64'd0);
        chk("rst_line_ready", {63'd0, line_ready}, 64'd0);
        chk("rst_perr", {63'd0, protocol_err}, 64'd0);
        chk("rst_rline", {63'd0, |rline}, 64'd0);
        reset = 1'b1;
        step();

        // Fill at 0x1230, request accepted after 3 cycles
        lv0 = lv_cnt;
        rq0 = req_cnt;
        do_fill(64'h1230, 64'd0, 15, 99, 3);
        @(negedge clk);
        chk("fill_line_valid", {63'd0, line_valid}, 64'd1);
        chk("fill_line_ready", {63'd0, line_ready}, 64'd0);
        check_rline(64'd0);
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        chk("fill_lv_pulses", 64'(lv_cnt - lv0), 64'd1);
        chk("fill_req_count", 64'(req_cnt - rq0), 64'd1);
        chk("fill_req_w_log", {63'd0, req_w}, 64'd0);
        chk("fill_req_a_log", req_a, 64'h1230);
        chk("fill_req_l_log", {60'd0, req_l}, 64'd15);
        chk("fill_perr", {63'd0, protocol_err}, 64'd0);

        // Writeback with toggling wready; low address bits must clear
        lr0 = lr_cnt;
        wb0 = wbeats;
        start_store(64'h4567, 64'hA0);
        g = 0;
        while ((wbeats - wb0) < 16 && g < 100) begin
            mem_wready = ~mem_wready;
            step();
            g++;
        end
        mem_wready = 1'b0;
        chk("wb_beats", 64'(wbeats - wb0), 64'd16);
        chk("wresp_wvalid", {63'd0, mem_wvalid}, 64'd0);
        step();
        step();
        mem_bvalid = 1'b1;
        step();
        mem_bvalid = 1'b0;
        @(negedge clk);
        chk("wb_line_ready", {63'd0, line_ready}, 64'd1);
        chk("wb_line_valid", {63'd0, line_valid}, 64'd0);
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        chk("wb_lr_pulses", 64'(lr_cnt - lr0), 64'd1);
        chk("wb_req_write", {63'd0, req_w}, 64'd1);
        chk("wb_req_addr", req_a, 64'h4560);
        nlast = 0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("wb_data_b%0d", k), wdat_log[wb0 + k],
                64'hA0 + 64'(k));
            if (wlast_log[wb0 + k]) nlast++;
        end
        chk("wb_wlast_count", 64'(nlast), 64'd1);
        chk("wb_wlast_b15", {63'd0, wlast_log[wb0 + 15]}, 64'd1);
        check_rline(64'd0);

        // Fill with rlast on beat 7
        lv0 = lv_cnt;
        do_fill(64'h0, 64'h100, 7, 99, 0);
        @(negedge clk);
        chk("err_line_valid", {63'd0, line_valid}, 64'd1);
        chk("err_perr", {63'd0, protocol_err}, 64'd1);
        check_rline(64'h100);
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        chk("err_perr_sticky", {63'd0, protocol_err}, 64'd1);
        chk("err_lv_pulses", 64'(lv_cnt - lv0), 64'd1);

        // Command dropped mid-burst
        lv0 = lv_cnt;
        rq0 = req_cnt;
        do_fill(64'h2000, 64'h200, 15, 3, 1);
        repeat (4) step();
        chk("drop_lv_pulses", 64'(lv_cnt - lv0), 64'd0);
        chk("drop_req_count", 64'(req_cnt - rq0), 64'd1);
        chk("drop_idle_req", {63'd0, mem_req_valid}, 64'd0);
        chk("drop_idle_wvalid", {63'd0, mem_wvalid}, 64'd0);

        // Reset during writeback at beat 5
        wb0 = wbeats;
        start_store(64'h3000, 64'hB0);
        mem_wready = 1'b1;
        g = 0;
        while ((wbeats - wb0) < 5 && g < 50) begin
            step();
            g++;
        end
        chk("mid_beats", 64'(wbeats - wb0), 64'd5);
        chk("mid_wvalid_pre", {63'd0, mem_wvalid}, 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_wvalid", {63'd0, mem_wvalid}, 64'd0);
        chk("mid_wlast", {63'd0, mem_wlast}, 64'd0);
        chk("mid_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("mid_line_ready", {63'd0, line_ready}, 64'd0);
        chk("mid_perr", {63'd0, protocol_err}, 64'd0);
        chk("mid_rline", {63'd0, |rline}, 64'd0);
        cmd_valid  = 1'b0;
        mem_wready = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();

        lv0 = lv_cnt;
        do_fill(64'h80, 64'h300, 15, 99, 0);
        @(negedge clk);
        chk("post_line_valid", {63'd0, line_valid}, 64'd1);
        check_rline(64'h300);
        step();
        cmd_valid = 1'b0;
        repeat (2) step();
        chk("post_lv_pulses", 64'(lv_cnt - lv0), 64'd1);
        chk("post_perr", {63'd0, protocol_err}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
